// File: rtl/array_queue_ctrl.sv
// Valid/ready FIFO controller around a 1R1W synchronous-read array macro.
// A one-entry output register hides the macro's one-cycle read latency.
module array_queue_ctrl #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int WIDTH = 420
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_bits,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_bits,
    output logic [AW:0]      count,
    output logic [AW-1:0]    mem_R0_addr,
    output logic             mem_R0_en,
    input  logic [WIDTH-1:0] mem_R0_data,
    output logic [AW-1:0]    mem_W0_addr,
    output logic             mem_W0_en,
    output logic [WIDTH-1:0] mem_W0_data
);

    localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      used;
    logic [AW:0]      unread;
    logic             rd_pend;
    logic             out_valid;
    logic [WIDTH-1:0] out_reg;

    logic enq_fire;
    logic deq_fire;
    logic issue;
    logic capture;
    logic stage_blocked;

    // A slot stays allocated until its read data has left the macro output,
    // so the write pointer can never overtake an in-flight read.
    assign enq_ready = ~flush & (used < DEPTH_V);
    assign enq_fire  = enq_valid & enq_ready;

    assign deq_valid = out_valid | rd_pend;
    assign deq_bits  = out_valid ? out_reg : mem_R0_data;
    assign deq_fire  = deq_valid & deq_ready & ~flush;

    // Issue only when the output stage will be free to take the data next cycle.
    assign stage_blocked = (out_valid | rd_pend) & ~(deq_valid & deq_ready);
    assign issue         = ~flush & (unread != '0) & ~stage_blocked;
    assign capture       = rd_pend & ~deq_fire;

    assign mem_W0_en   = enq_fire;
    assign mem_W0_addr = wptr;
    assign mem_W0_data = enq_bits;
    assign mem_R0_en   = issue;
    assign mem_R0_addr = rptr;

    assign count = used + {{AW{1'b0}}, out_valid};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            used      <= '0;
            unread    <= '0;
            rd_pend   <= 1'b0;
            out_valid <= 1'b0;
            out_reg   <= '0;
        end else if (flush) begin
            wptr      <= '0;
            rptr      <= '0;
            used      <= '0;
            unread    <= '0;
            rd_pend   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (enq_fire) begin
                wptr <= wptr + 1'b1;
            end
            if (issue) begin
                rptr <= rptr + 1'b1;
            end
            used    <= used + {{AW{1'b0}}, enq_fire} - {{AW{1'b0}}, rd_pend};
            unread  <= unread + {{AW{1'b0}}, enq_fire} - {{AW{1'b0}}, issue};
            rd_pend <= issue;
            // Pending read data that is not consumed directly parks in out_reg.
            if (capture) begin
                out_reg   <= mem_R0_data;
                out_valid <= 1'b1;
            end else if (out_valid & deq_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_array_queue_ctrl.sv
// Directed testbench for array_queue_ctrl with a behavioural model of the
// 64x420 registered-address array macro.
module tb_array_queue_ctrl;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int WIDTH = 420;

    logic             clock = 1'b0;
    logic             reset;
    logic             flush;
    logic             enq_valid;
    logic             enq_ready;
    logic [WIDTH-1:0] enq_bits;
    logic             deq_valid;
    logic             deq_ready;
    logic [WIDTH-1:0] deq_bits;
    logic [AW:0]      count;
    logic [AW-1:0]    mem_R0_addr;
    logic             mem_R0_en;
    logic [WIDTH-1:0] mem_R0_data;
    logic [AW-1:0]    mem_W0_addr;
    logic             mem_W0_en;
    logic [WIDTH-1:0] mem_W0_data;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] mem_model [DEPTH];
    logic [AW-1:0]    raddr_q;

    array_queue_ctrl #(.DEPTH(DEPTH), .AW(AW), .WIDTH(WIDTH)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_bits(enq_bits),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_bits(deq_bits),
        .count(count),
        .mem_R0_addr(mem_R0_addr), .mem_R0_en(mem_R0_en), .mem_R0_data(mem_R0_data),
        .mem_W0_addr(mem_W0_addr), .mem_W0_en(mem_W0_en), .mem_W0_data(mem_W0_data)
    );

    always #5 clock = ~clock;

    // Macro model: address registered on the edge, data read combinationally.
    always @(posedge clock) begin
        if (mem_W0_en) mem_model[mem_W0_addr] <= mem_W0_data;
        if (mem_R0_en) raddr_q <= mem_R0_addr;
    end
    assign mem_R0_data = mem_model[raddr_q];

    function automatic logic [WIDTH-1:0] mk(input int v);
        logic [20:0] p;
        p = v[20:0];
        return {20{p}};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0; enq_bits = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic fill(input int n, output int acc);
        acc = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            enq_valid = 1'b1;
            enq_bits  = mk(i);
            #1;
            if (enq_ready) acc++;
        end
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0; enq_bits = '0;
        repeat (2) @(posedge clock);
        #2;
        checks++;
        if (deq_valid !== 1'b0 || enq_ready !== 1'b1 || count !== 7'd0 ||
            mem_R0_en !== 1'b0 || mem_W0_en !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_state got dv=%b er=%b cnt=%0d r0=%b w0=%b exp dv=0 er=1 cnt=0 r0=0 w0=0",
                     deq_valid, enq_ready, count, mem_R0_en, mem_W0_en);
        end
        #1;
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        tick();
        enq_valid = 1'b1; enq_bits = mk(32'hA5); deq_ready = 1'b1;
        #1;
        checks++;
        if (mem_W0_en !== 1'b1 || mem_W0_addr !== 6'd0) begin
            failures++;
            $display("[TB] FAIL single_write got en=%b addr=%0d exp en=1 addr=0", mem_W0_en, mem_W0_addr);
        end
        tick();
        enq_valid = 1'b0;
        #1;
        checks++;
        if (mem_R0_en !== 1'b1 || mem_R0_addr !== 6'd0 || deq_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_read_issue got en=%b addr=%0d dv=%b exp en=1 addr=0 dv=0",
                     mem_R0_en, mem_R0_addr, deq_valid);
        end
        tick();
        #1;
        checks++;
        if (deq_valid !== 1'b1 || deq_bits !== mk(32'hA5) || count !== 7'd1) begin
            failures++;
            $display("[TB] FAIL single_deq got dv=%b bits=%h cnt=%0d exp dv=1 bits=%h cnt=1",
                     deq_valid, deq_bits, count, mk(32'hA5));
        end
        tick();
        #1;
        checks++;
        if (count !== 7'd0 || deq_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_empty got cnt=%0d dv=%b exp cnt=0 dv=0", count, deq_valid);
        end
    endtask

    task automatic test_fill_drain();
        int acc;
        do_reset();
        fill(70, acc);
        #1;
        checks++;
        if (acc != 65 || enq_ready !== 1'b0 || count !== 7'd65) begin
            failures++;
            $display("[TB] FAIL fill_capacity got acc=%0d er=%b cnt=%0d exp acc=65 er=0 cnt=65",
                     acc, enq_ready, count);
        end
        deq_ready = 1'b1;
        for (int k = 1; k <= 65; k++) begin
            if (k > 1) tick();
            #1;
            checks++;
            if (deq_valid !== 1'b1 || deq_bits !== mk(k)) begin
                failures++;
                $display("[TB] FAIL drain_item%0d got dv=%b bits=%h exp dv=1 bits=%h",
                         k, deq_valid, deq_bits, mk(k));
            end
        end
        tick();
        #1;
        checks++;
        if (deq_valid !== 1'b0 || count !== 7'd0) begin
            failures++;
            $display("[TB] FAIL drain_empty got dv=%b cnt=%0d exp dv=0 cnt=0", deq_valid, count);
        end
        deq_ready = 1'b0;
    endtask

    task automatic test_full_reopen();
        int acc;
        logic [WIDTH-1:0] exp;
        do_reset();
        fill(65, acc);
        deq_ready = 1'b1;
        #1;
        checks++;
        if (deq_valid !== 1'b1 || deq_bits !== mk(1) || enq_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reopen_head got dv=%b er=%b bits=%h exp dv=1 er=0 bits=%h",
                     deq_valid, enq_ready, deq_bits, mk(1));
        end
        tick();
        deq_ready = 1'b0;
        #1;
        checks++;
        if (enq_ready !== 1'b0 || count !== 7'd64) begin
            failures++;
            $display("[TB] FAIL reopen_t1 got er=%b cnt=%0d exp er=0 cnt=64", enq_ready, count);
        end
        tick();
        #1;
        checks++;
        if (enq_ready !== 1'b1 || count !== 7'd64) begin
            failures++;
            $display("[TB] FAIL reopen_t2 got er=%b cnt=%0d exp er=1 cnt=64", enq_ready, count);
        end
        enq_valid = 1'b1; enq_bits = mk(100);
        #1;
        checks++;
        if (mem_W0_en !== 1'b1 || mem_W0_addr !== 6'd1) begin
            failures++;
            $display("[TB] FAIL reopen_wrap_addr got en=%b addr=%0d exp en=1 addr=1", mem_W0_en, mem_W0_addr);
        end
        tick();
        enq_valid = 1'b0; deq_ready = 1'b1;
        for (int k = 0; k < 65; k++) begin
            if (k > 0) tick();
            #1;
            exp = (k < 64) ? mk(k + 2) : mk(100);
            checks++;
            if (deq_valid !== 1'b1 || deq_bits !== exp) begin
                failures++;
                $display("[TB] FAIL reopen_drain%0d got dv=%b bits=%h exp bits=%h", k, deq_valid, deq_bits, exp);
            end
        end
        deq_ready = 1'b0;
    endtask

    task automatic test_stream();
        do_reset();
        for (int c = 0; c < 202; c++) begin
            tick();
            enq_valid = (c < 200); enq_bits = mk(c); deq_ready = 1'b1;
            #1;
            checks++;
            if (dut.out_valid && dut.rd_pend) begin
                failures++;
                $display("[TB] FAIL stream_invariant cycle=%0d got ov&rp=1 exp 0", c);
            end
            checks++;
            if (c < 2) begin
                if (deq_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL stream_fill cycle=%0d got dv=%b exp 0", c, deq_valid);
                end
            end else if (deq_valid !== 1'b1 || deq_bits !== mk(c - 2) || (c < 200 && count !== 7'd2)) begin
                failures++;
                $display("[TB] FAIL stream_deq cycle=%0d got dv=%b cnt=%0d bits=%h exp bits=%h",
                         c, deq_valid, count, deq_bits, mk(c - 2));
            end
        end
        tick();
        enq_valid = 1'b0;
        #1;
        checks++;
        if (deq_valid !== 1'b0 || count !== 7'd0) begin
            failures++;
            $display("[TB] FAIL stream_end got dv=%b cnt=%0d exp dv=0 cnt=0", deq_valid, count);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] q[$];
        logic [WIDTH-1:0] exp;
        logic             pend_v;
        logic [AW-1:0]    pend_a;
        int               guard;
        do_reset();
        pend_v = 1'b0; pend_a = '0;
        for (int c = 0; c < 500; c++) begin
            tick();
            if (c < 400) begin
                enq_valid = 1'($urandom_range(0, 1));
                deq_ready = 1'($urandom_range(0, 1));
            end else begin
                enq_valid = 1'b0;
                deq_ready = 1'b1;
            end
            enq_bits = mk(1000 + c);
            #1;
            checks++;
            if (count !== 7'(q.size()) || (dut.out_valid && dut.rd_pend)) begin
                failures++;
                $display("[TB] FAIL random_count cycle=%0d got cnt=%0d ov=%b rp=%b exp cnt=%0d",
                         c, count, dut.out_valid, dut.rd_pend, q.size());
            end
            if (mem_W0_en) begin
                checks++;
                if ((pend_v && mem_W0_addr == pend_a) || (mem_R0_en && mem_W0_addr == mem_R0_addr)) begin
                    failures++;
                    $display("[TB] FAIL random_collision cycle=%0d got waddr=%0d exp not %0d/%0d",
                             c, mem_W0_addr, pend_a, mem_R0_addr);
                end
            end
            if (deq_valid && deq_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL random_spurious cycle=%0d got bits=%h exp no data", c, deq_bits);
                end else begin
                    exp = q.pop_front();
                    if (deq_bits !== exp) begin
                        failures++;
                        $display("[TB] FAIL random_data cycle=%0d got %h exp %h", c, deq_bits, exp);
                    end
                end
            end
            if (enq_valid && enq_ready) q.push_back(enq_bits);
            pend_v = mem_R0_en;
            pend_a = mem_R0_addr;
        end
        guard = 0;
        while (q.size() > 0 && guard < 300) begin
            tick();
            #1;
            if (deq_valid) begin
                exp = q.pop_front();
                checks++;
                if (deq_bits !== exp) begin
                    failures++;
                    $display("[TB] FAIL random_tail got %h exp %h", deq_bits, exp);
                end
            end
            guard++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("[TB] FAIL random_drain_timeout got left=%0d exp 0", q.size());
        end
        deq_ready = 1'b0;
    endtask

    task automatic test_flush();
        int acc;
        do_reset();
        fill(10, acc);
        enq_valid = 1'b1; enq_bits = mk(11); deq_ready = 1'b1;
        #1;
        checks++;
        if (deq_valid !== 1'b1 || deq_bits !== mk(1)) begin
            failures++;
            $display("[TB] FAIL flush_pre got dv=%b bits=%h exp bits=%h", deq_valid, deq_bits, mk(1));
        end
        tick();
        flush = 1'b1; enq_valid = 1'b1; enq_bits = mk(12); deq_ready = 1'b0;
        #1;
        checks++;
        if (count !== 7'd10 || deq_valid !== 1'b1 || enq_ready !== 1'b0 ||
            mem_W0_en !== 1'b0 || mem_R0_en !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_cycle got cnt=%0d dv=%b er=%b w0=%b r0=%b exp cnt=10 dv=1 er=0 w0=0 r0=0",
                     count, deq_valid, enq_ready, mem_W0_en, mem_R0_en);
        end
        tick();
        flush = 1'b0; enq_bits = mk(32'h3C);
        #1;
        checks++;
        if (count !== 7'd0 || deq_valid !== 1'b0 || mem_W0_en !== 1'b1 || mem_W0_addr !== 6'd0) begin
            failures++;
            $display("[TB] FAIL flush_after got cnt=%0d dv=%b w0=%b waddr=%0d exp cnt=0 dv=0 w0=1 waddr=0",
                     count, deq_valid, mem_W0_en, mem_W0_addr);
        end
        tick();
        enq_valid = 1'b0; deq_ready = 1'b1;
        tick();
        #1;
        checks++;
        if (deq_valid !== 1'b1 || deq_bits !== mk(32'h3C)) begin
            failures++;
            $display("[TB] FAIL flush_reenq got dv=%b bits=%h exp bits=%h", deq_valid, deq_bits, mk(32'h3C));
        end
        deq_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            tick();
            enq_valid = 1'b1; enq_bits = mk(500 + c); deq_ready = c[0];
        end
        @(posedge clock);
        #3;
        reset = 1'b1; enq_valid = 1'b0; deq_ready = 1'b0;
        #1;
        checks++;
        if (deq_valid !== 1'b0 || enq_ready !== 1'b1 || count !== 7'd0 ||
            mem_R0_en !== 1'b0 || mem_W0_en !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_reset got dv=%b er=%b cnt=%0d r0=%b w0=%b exp dv=0 er=1 cnt=0 r0=0 w0=0",
                     deq_valid, enq_ready, count, mem_R0_en, mem_W0_en);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout exp completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_full_reopen();
        test_stream();
        test_random();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
